// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port data memory between a CPU and a
// DMA engine.
//
// Arbitration
//   - IDLE: a lone requester is granted. When both request, the one that did
//     not win last time is granted (round-robin on last_win).
//   - A DMA grant from IDLE opens a burst. In DMA_BURST the DMA keeps the
//     memory for as long as it requests, up to MAX_BURST beats or until the
//     beat flagged with dma_last. A cycle without dma_req abandons the burst.
//   - A burst always leaves last_win = DMA, so a waiting CPU is granted next.
//
// Ports
//   CLK, RST                      clock; synchronous active-low reset
//   cpu_req/addr/wd/we            CPU single-beat access request
//   cpu_gnt, cpu_rd, cpu_rvalid   CPU grant, registered read data and valid
//   stall                         CPU must hold PC and instruction
//   dma_req/last/addr/wd/we       DMA beat request, last-beat flag
//   dma_gnt, dma_rd, dma_rvalid   DMA grant, registered read data and valid
//   mem_A, mem_WD, mem_WE         data-memory address, write data, lane enables
//   mem_RD                        combinational data-memory read data
module data_mem_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 17,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MAX_BURST     = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     cpu_req,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wd,
  input  logic [3:0]               cpu_we,
  output logic                     cpu_gnt,
  output logic [DATA_WIDTH-1:0]    cpu_rd,
  output logic                     cpu_rvalid,
  output logic                     stall,
  input  logic                     dma_req,
  input  logic                     dma_last,
  input  logic [ADDRESS_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0]    dma_wd,
  input  logic [3:0]               dma_we,
  output logic                     dma_gnt,
  output logic [DATA_WIDTH-1:0]    dma_rd,
  output logic                     dma_rvalid,
  output logic [ADDRESS_WIDTH-1:0] mem_A,
  output logic [DATA_WIDTH-1:0]    mem_WD,
  output logic [3:0]               mem_WE,
  input  logic [DATA_WIDTH-1:0]    mem_RD
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] DMA_BURST = 1'b1;

  localparam logic WIN_CPU = 1'b0;
  localparam logic WIN_DMA = 1'b1;

  localparam logic [3:0] MAX_BEATS = 4'(MAX_BURST);

  logic [0:0] state, state_next;
  logic       last_win, last_win_next;
  logic [3:0] beat_cnt, beat_cnt_next;
  logic [3:0] beat_inc;

  // Grants. Held low while reset is asserted so nothing reaches memory.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (RST) begin
      case (state)
        IDLE: begin
          if (cpu_req && dma_req) begin
            cpu_gnt = (last_win == WIN_DMA);
            dma_gnt = (last_win == WIN_CPU);
          end else begin
            cpu_gnt = cpu_req;
            dma_gnt = dma_req;
          end
        end
        DMA_BURST: dma_gnt = dma_req;
        default: ;
      endcase
    end
  end

  assign stall = cpu_req & ~cpu_gnt;

  // Next-state: burst bookkeeping and round-robin history.
  always_comb begin
    state_next    = state;
    last_win_next = last_win;
    beat_cnt_next = beat_cnt;
    beat_inc      = beat_cnt + 4'd1;

    if (cpu_gnt) begin
      last_win_next = WIN_CPU;
    end

    case (state)
      IDLE: begin
        if (dma_gnt) begin
          last_win_next = WIN_DMA;
          beat_cnt_next = 4'd1;
          if (!dma_last && (MAX_BEATS != 4'd1)) begin
            state_next = DMA_BURST;
          end
        end
      end
      DMA_BURST: begin
        if (dma_gnt) begin
          last_win_next = WIN_DMA;
          beat_cnt_next = beat_inc;
          if (dma_last || (beat_inc >= MAX_BEATS)) begin
            state_next    = IDLE;
            beat_cnt_next = 4'd0;
          end
        end else begin
          // Requester went quiet mid-burst: give the memory back.
          state_next    = IDLE;
          beat_cnt_next = 4'd0;
        end
      end
      default: begin
        state_next    = IDLE;
        beat_cnt_next = 4'd0;
      end
    endcase
  end

  // Memory port mux; an ungranted requester's enables never reach memory.
  always_comb begin
    mem_A  = '0;
    mem_WD = '0;
    mem_WE = 4'b0000;
    if (cpu_gnt) begin
      mem_A  = cpu_addr;
      mem_WD = cpu_wd;
      mem_WE = cpu_we;
    end else if (dma_gnt) begin
      mem_A  = dma_addr;
      mem_WD = dma_wd;
      mem_WE = dma_we;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      last_win   <= WIN_DMA;
      beat_cnt   <= 4'd0;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      cpu_rd     <= '0;
      dma_rd     <= '0;
    end else begin
      state      <= state_next;
      last_win   <= last_win_next;
      beat_cnt   <= beat_cnt_next;
      cpu_rvalid <= cpu_gnt && (cpu_we == 4'b0000);
      dma_rvalid <= dma_gnt && (dma_we == 4'b0000);
      if (cpu_gnt && (cpu_we == 4'b0000)) begin
        cpu_rd <= mem_RD;
      end
      if (dma_gnt && (dma_we == 4'b0000)) begin
        dma_rd <= mem_RD;
      end
    end
  end

endmodule
